// File: rtl/terminal_grid_writer.sv
// terminal_grid_writer: turns a stream of ASCII bytes into writes on the
// terminal-grid BRAM port and keeps the text cursor. Printable bytes are
// stored at the cursor. Newline (10) and a write in the last column advance
// the row and blank the new row. Backspace (8) erases the previous cell.
// Form feed (12) blanks the whole screen.
// Optional build macro TERMINAL_GRID_WRITER_CURSOR_EN: after each command,
// one extra cycle draws '|' (124) at the new cursor position.
//
// Handshake: a byte is taken on a rising edge where char_valid_in and
// char_ready_out are both high. char_ready_out is low from the accepting
// edge until the command's last write cycle has finished. A source that sees
// ready low must hold char_in and char_valid_in stable.
module terminal_grid_writer #(
  parameter int SCREEN_WIDTH  = 76,
  parameter int SCREEN_HEIGHT = 44,
  parameter int ADDR_W        = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT)
) (
  input  logic                             pixel_clk_in,
  input  logic                             rst_n_in,
  input  logic [7:0]                       char_in,
  input  logic                             char_valid_in,
  output logic                             char_ready_out,
  output logic                             tg_write_en,
  output logic [ADDR_W-1:0]                tg_addr,
  output logic [7:0]                       tg_input,
  output logic [$clog2(SCREEN_WIDTH)-1:0]  cursor_col_out,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] cursor_row_out,
  output logic                             busy_out
);

  localparam int COL_W = $clog2(SCREEN_WIDTH);
  localparam int ROW_W = $clog2(SCREEN_HEIGHT);
  localparam logic [ADDR_W-1:0] LINE_N = ADDR_W'(SCREEN_WIDTH);
  localparam logic [ADDR_W-1:0] ALL_N  = ADDR_W'(SCREEN_WIDTH*SCREEN_HEIGHT);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(SCREEN_WIDTH-1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(SCREEN_HEIGHT-1);
  localparam logic [7:0] CH_BS    = 8'd8;
  localparam logic [7:0] CH_NL    = 8'd10;
  localparam logic [7:0] CH_FF    = 8'd12;
  localparam logic [7:0] CH_SPACE = 8'd32;
  localparam logic [7:0] CH_BAR   = 8'd124;

`ifdef TERMINAL_GRID_WRITER_CURSOR_EN
  localparam bit CURSOR_EN = 1'b1;
`else
  localparam bit CURSOR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;   // next cell index of a clear sweep
  logic                cur_q, cur_d;   // cursor glyph already drawn for the last command

  logic                accept;
  logic                is_bs, is_nl, is_ff;
  logic                last_col;
  logic [ROW_W-1:0]    next_row;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_W-1:0] r,
                                                input logic [COL_W-1:0] c);
    addr_of = ADDR_W'(r) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(c);
  endfunction

  assign accept   = (state_q == IDLE) && ready_q && char_valid_in;
  assign is_bs    = (char_in == CH_BS);
  assign is_nl    = (char_in == CH_NL);
  assign is_ff    = (char_in == CH_FF);
  assign last_col = (col_q == LAST_COL);
  assign next_row = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;

  // State and all output registers; reset drops everything at once.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      cur_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
    end
  end

  // Next state: clears are entered on accept and left once the sweep is done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_ff)                              state_d = CLR_ALL;
          else if (is_nl || (!is_bs && last_col)) state_d = CLR_LINE;
        end
      end
      CLR_LINE: if (cnt_q == LINE_N) state_d = IDLE;
      CLR_ALL:  if (cnt_q == ALL_N)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output/datapath next values: one grid write per cycle at most.
  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ready_d = 1'b0;
          cur_d   = 1'b0;
          if (is_ff) begin
            // Cell 0 goes out now; the sweep continues from cell 1.
            we_d   = 1'b1;
            addr_d = '0;
            data_d = CH_SPACE;
            cnt_d  = ADDR_W'(1);
            col_d  = '0;
            row_d  = '0;
            busy_d = 1'b1;
          end else if (is_nl) begin
            we_d   = 1'b1;
            addr_d = addr_of(next_row, '0);
            data_d = CH_SPACE;
            cnt_d  = ADDR_W'(1);
            col_d  = '0;
            row_d  = next_row;
            busy_d = 1'b1;
          end else if (is_bs) begin
            if (col_q != '0) begin
              we_d   = 1'b1;
              col_d  = col_q - 1'b1;
              addr_d = addr_of(row_q, col_q - 1'b1);
              data_d = CH_SPACE;
            end else if (row_q != '0) begin
              we_d   = 1'b1;
              col_d  = LAST_COL;
              row_d  = row_q - 1'b1;
              addr_d = addr_of(row_q - 1'b1, LAST_COL);
              data_d = CH_SPACE;
            end
          end else begin
            we_d   = 1'b1;
            addr_d = addr_of(row_q, col_q);
            data_d = char_in;
            if (last_col) begin
              // The blanking of the new row starts on the following cycle.
              col_d  = '0;
              row_d  = next_row;
              cnt_d  = '0;
              busy_d = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end else if (!ready_q) begin
          if (CURSOR_EN && !cur_q) begin
            we_d   = 1'b1;
            addr_d = addr_of(row_q, col_q);
            data_d = CH_BAR;
            cur_d  = 1'b1;
          end else begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      CLR_LINE, CLR_ALL: begin
        if ((state_q == CLR_LINE && cnt_q == LINE_N) ||
            (state_q == CLR_ALL  && cnt_q == ALL_N)) begin
          busy_d = 1'b0;
          if (CURSOR_EN) begin
            we_d   = 1'b1;
            addr_d = addr_of(row_q, col_q);
            data_d = CH_BAR;
            cur_d  = 1'b1;
          end else begin
            ready_d = 1'b1;
          end
        end else begin
          we_d   = 1'b1;
          addr_d = (state_q == CLR_LINE) ? addr_of(row_q, cnt_q[COL_W-1:0]) : cnt_q;
          data_d = CH_SPACE;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign char_ready_out = ready_q;
  assign tg_write_en    = we_q;
  assign tg_addr        = addr_q;
  assign tg_input       = data_q;
  assign cursor_col_out = col_q;
  assign cursor_row_out = row_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_terminal_grid_writer.sv
// Bench for terminal_grid_writer (default build, cursor glyph disabled).
module tb_terminal_grid_writer;

  localparam int W = 76;
  localparam int H = 44;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ch = 8'd0;
  logic        valid = 1'b0;
  logic        ready, we, busy;
  logic [11:0] addr;
  logic [7:0]  data;
  logic [6:0]  col;
  logic [5:0]  row;

  terminal_grid_writer dut (
    .pixel_clk_in   (clk),
    .rst_n_in       (rst_n),
    .char_in        (ch),
    .char_valid_in  (valid),
    .char_ready_out (ready),
    .tg_write_en    (we),
    .tg_addr        (addr),
    .tg_input       (data),
    .cursor_col_out (col),
    .cursor_row_out (row),
    .busy_out       (busy)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled on the falling edge
  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    int          cyc;
    logic        ready;
    logic        busy;
  } wr_t;
  wr_t obs_q[$];
  logic [19:0] exp_q[$];

  always @(negedge clk)
    if (rst_n && we) obs_q.push_back('{addr, data, cyc, ready, busy});

  int tests = 0;
  int fails = 0;
  int acc_cyc = 0;
  int idle_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present a byte, hold it until taken; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] c);
    int b = 0;
    ch = c;
    valid = 1'b1;
    while (!ready && b < 5000) begin
      @(negedge clk);
      b++;
    end
    if (!ready) begin
      check("send_timeout", 0, 1);
      valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    valid = 1'b0;
  endtask

  // Wait (bounded) until ready is back; ends on a falling edge.
  task automatic wait_idle();
    int b = 0;
    @(negedge clk);
    while (!ready && b < 5000) begin
      @(negedge clk);
      b++;
    end
    idle_cyc = cyc;
    if (!ready) check("idle_timeout", 0, 1);
  endtask

  task automatic run_cmd(input logic [7:0] c);
    send_byte(c);
    wait_idle();
  endtask

  task automatic clear_queues();
    obs_q.delete();
    exp_q.delete();
  endtask

  // Scoreboard: compare captured writes with the expected queue, then empty both.
  task automatic expect_writes(input string name);
    int bad = 0;
    int n;
    check({name, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if ({obs_q[i].addr, obs_q[i].data} != exp_q[i]) begin
        if (bad == 0)
          $display("FAIL %s_write%0d: got addr %0d data %0d expected addr %0d data %0d",
                   name, i, obs_q[i].addr, obs_q[i].data, exp_q[i][19:8], exp_q[i][7:0]);
        bad++;
      end
    end
    tests++;
    if (bad != 0) fails++;
    clear_queues();
  endtask

  task automatic check_cursor(input string name, input int r, input int c);
    check({name, "_row"}, row, r);
    check({name, "_col"}, col, c);
  endtask

  typedef struct {
    logic [7:0] c;
    int         nwr;
    int         addr;
    int         data;
    int         row;
    int         col;
  } vec_t;
  vec_t vecs[9];

  initial begin
    // Single-write commands from a fresh screen, expected values by hand
    vecs[0] = '{8'd104, 1, 0, 104, 0, 1};
    vecs[1] = '{8'd105, 1, 1, 105, 0, 2};
    vecs[2] = '{8'd8,   1, 1, 32,  0, 1};
    vecs[3] = '{8'd8,   1, 0, 32,  0, 0};
    vecs[4] = '{8'd8,   0, 0, 0,   0, 0};
    vecs[5] = '{8'd65,  1, 0, 65,  0, 1};
    vecs[6] = '{8'd127, 1, 1, 127, 0, 2};
    vecs[7] = '{8'd0,   1, 2, 0,   0, 3};
    vecs[8] = '{8'd8,   1, 2, 32,  0, 2};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_we", we, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    check_cursor("rst", 0, 0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", ready, 0);
    @(negedge clk);
    check("ready_first_edge", ready, 1);

    // Table-driven single commands
    for (int i = 0; i < 9; i++) begin
      clear_queues();
      if (vecs[i].nwr != 0) exp_q.push_back({12'(vecs[i].addr), 8'(vecs[i].data)});
      run_cmd(vecs[i].c);
      if (vecs[i].nwr != 0 && obs_q.size() > 0)
        check($sformatf("vec%0d_latency", i), obs_q[0].cyc, acc_cyc);
      expect_writes($sformatf("vec%0d", i));
      check_cursor($sformatf("vec%0d", i), vecs[i].row, vecs[i].col);
    end

    // Wrap from (3,75): char at 303, then row 4 blanked at 304..379
    for (int i = 0; i < 3; i++) run_cmd(8'd10);
    for (int i = 0; i < 75; i++) run_cmd(8'd120);
    check_cursor("pos_3_75", 3, 75);
    clear_queues();
    exp_q.push_back({12'd303, 8'd97});
    for (int a = 304; a < 380; a++) exp_q.push_back({12'(a), 8'd32});
    send_byte(8'd97);
    wait_idle();
    begin
      int rdy_hi = 0;
      int busy_lo = 0;
      foreach (obs_q[i]) begin
        if (obs_q[i].ready) rdy_hi++;
        if (i > 0 && !obs_q[i].busy) busy_lo++;
      end
      check("wrap_ready_low", rdy_hi, 0);
      check("wrap_busy_high", busy_lo, 0);
      if (obs_q.size() > 0) begin
        check("wrap_latency", obs_q[0].cyc, acc_cyc);
        check("wrap_ready_return", idle_cyc - obs_q[obs_q.size()-1].cyc, 1);
      end
    end
    expect_writes("wrap");
    check_cursor("wrap", 4, 0);

    // Newline on the last row wraps to row 0 and blanks it
    for (int i = 0; i < 39; i++) run_cmd(8'd10);
    for (int i = 0; i < 10; i++) run_cmd(8'd121);
    check_cursor("pos_43_10", 43, 10);
    clear_queues();
    for (int a = 0; a < W; a++) exp_q.push_back({12'(a), 8'd32});
    send_byte(8'd10);
    wait_idle();
    if (obs_q.size() > 0) check("nl_latency", obs_q[0].cyc, acc_cyc);
    expect_writes("nl_wrap");
    check_cursor("nl_wrap", 0, 0);

    // Backspace at column 0 goes to the end of the previous row
    run_cmd(8'd10);
    run_cmd(8'd10);
    check_cursor("pos_2_0", 2, 0);
    clear_queues();
    exp_q.push_back({12'(1*W + 75), 8'd32});
    run_cmd(8'd8);
    expect_writes("bs_row");
    check_cursor("bs_row", 1, 75);

    // Form feed blanks every cell in order
    clear_queues();
    for (int a = 0; a < W*H; a++) exp_q.push_back({12'(a), 8'd32});
    send_byte(8'd12);
    wait_idle();
    begin
      int busy_lo = 0;
      int rdy_hi = 0;
      foreach (obs_q[i]) begin
        if (!obs_q[i].busy) busy_lo++;
        if (obs_q[i].ready) rdy_hi++;
      end
      check("ff_busy_high", busy_lo, 0);
      check("ff_ready_low", rdy_hi, 0);
      if (obs_q.size() > 0) begin
        check("ff_latency", obs_q[0].cyc, acc_cyc);
        check("ff_ready_return", idle_cyc - obs_q[obs_q.size()-1].cyc, 1);
      end
    end
    expect_writes("ff");
    check_cursor("ff", 0, 0);
    check("ff_busy_after", busy, 0);

    // Backspace at (0,0) writes nothing
    clear_queues();
    run_cmd(8'd8);
    expect_writes("bs_origin");
    check_cursor("bs_origin", 0, 0);

    // Reset in the middle of a form feed
    run_cmd(8'd65);
    clear_queues();
    send_byte(8'd12);
    begin
      int b = 0;
      while (obs_q.size() < 1000 && b < 5000) begin
        @(negedge clk);
        b++;
      end
      check("ff_reached_1000", obs_q.size() >= 1000, 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_we", we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", ready, 0);
    check_cursor("midrst", 0, 0);
    repeat (3) @(negedge clk);
    clear_queues();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_back", ready, 1);
    check("midrst_no_resume", obs_q.size(), 0);
    exp_q.push_back({12'd0, 8'd104});
    run_cmd(8'd104);
    expect_writes("after_rst");
    check_cursor("after_rst", 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
